instr_encoder: RTL and testbench

//  Program loader and encoder; the inverse of the opcode decoder. Accepts field-level

---
 rtl/instr_encoder.sv | 223 ++++++++++++++++++++++
 tb/tb_instr_encoder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: program loader that turns field-level commands into RV32I words
// and streams them into instruction memory at consecutive word addresses.
// An optional HALT word (opcode 7'b1111111) terminates the program.
// Optional feature macro: IMM_CHECK_EN (immediate range checking drives err).
module instr_encoder #(
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_class,
    input  logic [2:0]        cmd_funct3,
    input  logic              cmd_f7b5,
    input  logic [4:0]        cmd_rd,
    input  logic [4:0]        cmd_rs1,
    input  logic [4:0]        cmd_rs2,
    input  logic [31:0]       cmd_imm,
    input  logic              cmd_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              err
);

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [31:0]       HALT_WORD = 32'h0000_007F;

    localparam logic [2:0] CLS_R    = 3'd0;
    localparam logic [2:0] CLS_I    = 3'd1;
    localparam logic [2:0] CLS_LD   = 3'd2;
    localparam logic [2:0] CLS_ST   = 3'd3;
    localparam logic [2:0] CLS_BR   = 3'd4;
    localparam logic [2:0] CLS_LUI  = 3'd5;
    localparam logic [2:0] CLS_JAL  = 3'd6;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_HALT,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              last_q, last_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              accept_c;

    // Shift-immediate forms of OP-IMM carry funct7[5] in the upper immediate bits.
    function automatic logic is_shift(input logic [2:0] f3);
        return (f3 == 3'b001) || (f3 == 3'b101);
    endfunction

    // Assemble the 32-bit word; immediates are simply truncated to their fields.
    function automatic logic [31:0] encode(
        input logic [2:0]  cls,
        input logic [2:0]  f3,
        input logic        f7b5,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [31:0] imm
    );
        logic [31:0] w;
        case (cls)
            CLS_R:   w = {1'b0, f7b5, 5'b0, rs2, rs1, f3, rd, OP_R};
            CLS_I: begin
                if (is_shift(f3)) w = {1'b0, f7b5, 5'b0, imm[4:0], rs1, f3, rd, OP_I};
                else              w = {imm[11:0], rs1, f3, rd, OP_I};
            end
            CLS_LD:  w = {imm[11:0], rs1, f3, rd, OP_LD};
            CLS_ST:  w = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_ST};
            CLS_BR:  w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BR};
            CLS_LUI: w = {imm[31:12], rd, OP_LUI};
            CLS_JAL: w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            default: w = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
        endcase
        return w;
    endfunction

    // ready_q is only ever high in IDLE, so it doubles as the state qualifier.
    assign accept_c = cmd_valid & ready_q & ~restart;

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        wdata_d = wdata_q;
        last_d  = last_q;
        ovf_d   = ovf_q;
        if (restart) begin
            state_d = S_IDLE;
            addr_d  = BASE;
            last_d  = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        state_d = S_WRITE;
                        we_d    = 1'b1;
                        wdata_d = encode(cmd_class, cmd_funct3, cmd_f7b5,
                                         cmd_rd, cmd_rs1, cmd_rs2, cmd_imm);
                        last_d  = cmd_last;
                    end
                end
                S_WRITE: begin
                    if (addr_q == LAST_ADDR) begin
                        // No room left for another word, HALT included.
                        state_d = S_DONE;
                        ovf_d   = 1'b1;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                        if (last_q) begin
                            state_d = S_HALT;
                            we_d    = 1'b1;
                            wdata_d = HALT_WORD;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_HALT:  state_d = S_DONE;
                default: state_d = S_DONE;
            endcase
        end
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d == S_WRITE) || (state_d == S_HALT);
        done_d  = (state_d == S_DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= BASE;
            we_q    <= 1'b0;
            wdata_q <= 32'h0;
            last_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef IMM_CHECK_EN
    logic err_q;

    // True when the immediate cannot be represented by the class's field.
    function automatic logic imm_bad(input logic [2:0] cls, input logic [2:0] f3,
                                     input logic [31:0] imm);
        logic fits12, fits13, fits21;
        fits12 = (imm[31:11] == '0) || (imm[31:11] == '1);
        fits13 = (imm[31:12] == '0) || (imm[31:12] == '1);
        fits21 = (imm[31:20] == '0) || (imm[31:20] == '1);
        case (cls)
            CLS_R:   return 1'b0;
            CLS_I:   return is_shift(f3) ? (|imm[31:5]) : !fits12;
            CLS_BR:  return imm[0] | !fits13;
            CLS_LUI: return |imm[11:0];
            CLS_JAL: return imm[0] | !fits21;
            default: return !fits12;
        endcase
    endfunction

    // Sticky range error, sampled with the command at accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (restart) begin
            err_q <= 1'b0;
        end else if (accept_c && imm_bad(cmd_class, cmd_funct3, cmd_imm)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign cmd_ready  = ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder: a full-size instance for encoding and
// control checks, and a 4-word instance for the overflow path.
module tb_instr_encoder;

`ifdef IMM_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        restart, restart_b;
    logic        cmd_valid, valid_b;
    logic        cmd_ready, ready_b;
    logic [2:0]  cmd_class, cmd_funct3;
    logic        cmd_f7b5;
    logic [4:0]  cmd_rd, cmd_rs1, cmd_rs2;
    logic [31:0] cmd_imm;
    logic        cmd_last;
    logic        imem_we, we_b;
    logic [8:0]  imem_addr;
    logic [1:0]  addr_b;
    logic [31:0] imem_wdata, wdata_b;
    logic        busy, busy_b, done, done_b, overflow, ovf_b, err, err_b;

    logic [31:0] mem [0:511];
    int          n_cmp = 0;
    int          n_err = 0;

    instr_encoder #(.ADDR_W(9), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .restart(restart),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_class(cmd_class), .cmd_funct3(cmd_funct3), .cmd_f7b5(cmd_f7b5),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .cmd_imm(cmd_imm), .cmd_last(cmd_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .overflow(overflow), .err(err)
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_small (
        .clk(clk), .rst_n(rst_n), .restart(restart_b),
        .cmd_valid(valid_b), .cmd_ready(ready_b),
        .cmd_class(cmd_class), .cmd_funct3(cmd_funct3), .cmd_f7b5(cmd_f7b5),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .cmd_imm(cmd_imm), .cmd_last(cmd_last),
        .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b),
        .busy(busy_b), .done(done_b), .overflow(ovf_b), .err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture what the large instance writes into its memory.
    always @(posedge clk) begin
        if (imem_we) mem[imem_addr] <= imem_wdata;
    end

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Issue one command on the large instance; call at a negedge, returns in the WRITE cycle.
    task automatic send(input logic [2:0] cls, input logic [2:0] f3, input logic f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic last,
                        input logic [31:0] exp_addr, input logic [31:0] exp_word,
                        input string tag);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready_wait"}, 32'(n < 20), 32'd1);
        cmd_class = cls; cmd_funct3 = f3; cmd_f7b5 = f7;
        cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm; cmd_last = last;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_class = 3'($urandom); cmd_funct3 = 3'($urandom); cmd_f7b5 = 1'($urandom);
        cmd_rd = 5'($urandom); cmd_rs1 = 5'($urandom); cmd_rs2 = 5'($urandom);
        cmd_imm = $urandom; cmd_last = 1'($urandom);
        chk({tag, "_we"},    32'(imem_we),   32'd1);
        chk({tag, "_addr"},  32'(imem_addr), exp_addr);
        chk({tag, "_word"},  imem_wdata,     exp_word);
        chk({tag, "_ready"}, 32'(cmd_ready), 32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd1);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; restart = 1'b0; restart_b = 1'b0;
        cmd_valid = 1'b0; valid_b = 1'b0;
        cmd_class = '0; cmd_funct3 = '0; cmd_f7b5 = 1'b0;
        cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm = '0; cmd_last = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_we",    32'(imem_we),   32'd0);
        chk("rst_addr",  32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wdata,     32'h0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_ovf",   32'(overflow),  32'd0);
        chk("rst_err",   32'(err),       32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);

        // 1: addi x1,x0,5; ready is low for exactly one cycle
        send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'd0, 32'h0050_0093, "addi");
        @(negedge clk);
        chk("addi_ready_back", 32'(cmd_ready), 32'd1);
        chk("addi_we_drop",    32'(imem_we),   32'd0);
        chk("addi_addr_inc",   32'(imem_addr), 32'd1);

        // 2: add x3,x1,x2; sw x3,8(x0) with last -> HALT then DONE
        send(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'd1, 32'h0020_81B3, "add");
        send(3'd3, 3'd2, 1'b0, 5'd0, 5'd0, 5'd3, 32'd8, 1'b1, 32'd2, 32'h0030_2423, "sw");
        @(negedge clk);
        chk("halt_we",    32'(imem_we),   32'd1);
        chk("halt_addr",  32'(imem_addr), 32'd3);
        chk("halt_word",  imem_wdata,     32'h0000_007F);
        chk("halt_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        chk("done_flag",  32'(done),      32'd1);
        chk("done_busy",  32'(busy),      32'd0);
        chk("done_ready", 32'(cmd_ready), 32'd0);
        chk("done_we",    32'(imem_we),   32'd0);
        chk("done_ovf",   32'(overflow),  32'd0);
        chk("mem0", mem[0], 32'h0050_0093);
        chk("mem1", mem[1], 32'h0020_81B3);
        chk("mem2", mem[2], 32'h0030_2423);
        chk("mem3", mem[3], 32'h0000_007F);
        @(negedge clk);
        chk("done_hold", 32'(done), 32'd1);
        pulse_restart();
        chk("rs_done",  32'(done),      32'd0);
        chk("rs_addr",  32'(imem_addr), 32'd0);
        chk("rs_ready", 32'(cmd_ready), 32'd1);

        // 3: assorted encodings
        send(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd8, 1'b0, 32'd0, 32'hFE20_8CE3, "beq");
        send(3'd6, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd16, 1'b0, 32'd1, 32'h0100_00EF, "jal");
        send(3'd5, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0, 32'd2, 32'h1234_52B7, "lui");
        send(3'd1, 3'd5, 1'b1, 5'd4, 5'd1, 5'd0, 32'd3, 1'b0, 32'd3, 32'h4030_D213, "srai");
        send(3'd2, 3'd2, 1'b0, 5'd6, 5'd2, 5'd0, -32'sd4, 1'b0, 32'd4, 32'hFFC1_2303, "lw");
        send(3'd7, 3'd3, 1'b0, 5'd1, 5'd5, 5'd0, 32'd4, 1'b0, 32'd5, 32'h0042_80E7, "jalr");
        send(3'd0, 3'd0, 1'b1, 5'd7, 5'd1, 5'd2, 32'd0, 1'b0, 32'd6, 32'h4020_83B3, "sub");
        @(negedge clk);
        chk("seq_addr", 32'(imem_addr), 32'd7);

        // restart and a command on the same edge: command is dropped
        cmd_class = 3'd1; cmd_rd = 5'd9; cmd_imm = 32'd1; cmd_last = 1'b0;
        cmd_valid = 1'b1; restart = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; restart = 1'b0;
        chk("rsv_we",    32'(imem_we),   32'd0);
        chk("rsv_addr",  32'(imem_addr), 32'd0);
        chk("rsv_ready", 32'(cmd_ready), 32'd1);
        chk("rsv_busy",  32'(busy),      32'd0);

        // restart during WRITE: that write lands, address is not advanced
        send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'd0, 32'h0050_0093, "addi_rw");
        pulse_restart();
        chk("rw_we",    32'(imem_we),   32'd0);
        chk("rw_addr",  32'(imem_addr), 32'd0);
        chk("rw_ready", 32'(cmd_ready), 32'd1);
        chk("rw_mem0",  mem[0],         32'h0050_0093);

        // 5: out-of-range immediate; word is still written truncated
        send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b0, 32'd0, 32'h0000_0093, "addi4096");
        @(negedge clk);
        chk("err_set", 32'(err), 32'(ERR_EXP));
        pulse_restart();
        chk("err_clr", 32'(err), 32'd0);

        // 6: async reset in the middle of a WRITE
        send(3'd1, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd7, 1'b0, 32'd0, 32'h0070_0113, "addi_a");
        send(3'd1, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'd9, 1'b0, 32'd1, 32'h0090_0193, "addi_b");
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we",    32'(imem_we),   32'd0);
        chk("arst_addr",  32'(imem_addr), 32'd0);
        chk("arst_ready", 32'(cmd_ready), 32'd0);
        chk("arst_busy",  32'(busy),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_ready_back", 32'(cmd_ready), 32'd1);

        // 4: 4-word memory, no last -> overflow
        for (int i = 0; i < 4; i++) begin
            int n;
            n = 0;
            while (ready_b !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("ovf_ready_wait", 32'(n < 20), 32'd1);
            cmd_class = 3'd1; cmd_funct3 = 3'd0; cmd_f7b5 = 1'b0;
            cmd_rd = 5'd1; cmd_rs1 = 5'd0; cmd_rs2 = 5'd0;
            cmd_imm = 32'(i); cmd_last = 1'b0;
            valid_b = 1'b1;
            @(negedge clk);
            valid_b = 1'b0;
            chk("ovf_we",   32'(we_b),   32'd1);
            chk("ovf_addr", 32'(addr_b), 32'(i));
            chk("ovf_word", wdata_b,     (32'(i) << 20) | 32'h0000_0093);
        end
        @(negedge clk);
        chk("ovf_done",  32'(done_b),  32'd1);
        chk("ovf_flag",  32'(ovf_b),   32'd1);
        chk("ovf_rdy",   32'(ready_b), 32'd0);
        chk("ovf_we0",   32'(we_b),    32'd0);
        chk("ovf_busy",  32'(busy_b),  32'd0);
        restart_b = 1'b1;
        @(negedge clk);
        restart_b = 1'b0;
        chk("ovf_rs_addr",  32'(addr_b),  32'd0);
        chk("ovf_rs_done",  32'(done_b),  32'd0);
        chk("ovf_rs_flag",  32'(ovf_b),   32'd0);
        chk("ovf_rs_ready", 32'(ready_b), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
